byte_serializer: RTL

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_convert_pkg.sv | 23 ++
 rtl/read_return_pipe.sv | 45 ++++
 rtl/byte_serializer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/byte_convert_pkg.sv
// Shared types and sizing helpers for the byte_serializer width converter.
package byte_convert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_USE_DATA_BYTE = 8;
    localparam int DEFAULT_MEM_DATA_BYTE = 4;

    function automatic int calc_ratio(input int use_bytes, input int mem_bytes);
        return (mem_bytes > 0) ? use_bytes / mem_bytes : 0;
    endfunction

    // A ratio of 2 still needs a one-bit beat index.
    function automatic int calc_idx_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/read_return_pipe.sv
// Tracks which buffer slot each outstanding read beat returns into.
module read_return_pipe #(
    parameter int LATENCY = 1,
    parameter int IDX_W   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             ret_valid,
    output logic [IDX_W-1:0] ret_idx,
    output logic             pending
);

    logic [LATENCY-1:0] valid_q;
    logic [IDX_W-1:0]   idx_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push;
            idx_q[0]   <= push_idx;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    // The last stage lines up with the cycle the memory presents the data.
    assign ret_valid = valid_q[LATENCY-1];
    assign ret_idx   = idx_q[LATENCY-1];

    // Beats still travelling behind the one returning this cycle.
    if (LATENCY > 1) begin : g_pending
        assign pending = |valid_q[LATENCY-2:0];
    end else begin : g_no_pending
        assign pending = 1'b0;
    end

endmodule

// File: rtl/byte_serializer.sv
// Splits one wide user access into a burst of narrow memory beats and
// reassembles read data into a full user word.
module byte_serializer
    import byte_convert_pkg::*;
#(
    parameter int USE_DATA_BYTE = DEFAULT_USE_DATA_BYTE,
    parameter int MEM_DATA_BYTE = DEFAULT_MEM_DATA_BYTE,
    parameter int ADDR_SIZE     = 32,
    parameter int READ_LATENCY  = 1,
    parameter int SKIP_EMPTY    = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       useEnable_i,
    input  logic                       useIsWrite_i,
    input  logic [USE_DATA_BYTE-1:0]   useWriteMask_i,
    input  logic [ADDR_SIZE-1:0]       useAddr_i,
    input  logic [USE_DATA_BYTE*8-1:0] useWriteData_i,
    output logic [USE_DATA_BYTE*8-1:0] useReadData_o,
    output logic                       useHold_o,
    output logic                       memEnable_o,
    output logic                       memIsWrite_o,
    output logic [MEM_DATA_BYTE-1:0]   memWriteMask_o,
    output logic [ADDR_SIZE-1:0]       memAddr_o,
    output logic [MEM_DATA_BYTE*8-1:0] memWriteData_o,
    input  logic [MEM_DATA_BYTE*8-1:0] memReadData_i,
    input  logic                       memHold_i
);

    localparam int RATIO     = calc_ratio(USE_DATA_BYTE, MEM_DATA_BYTE);
    localparam int IDX_W     = calc_idx_w(RATIO);
    localparam int MEM_BITS  = MEM_DATA_BYTE * 8;
    localparam int USE_BITS  = USE_DATA_BYTE * 8;
    localparam int USE_SHIFT = $clog2(USE_DATA_BYTE);
    localparam logic [ADDR_SIZE-1:0] BASE_MASK =
        {{(ADDR_SIZE-USE_SHIFT){1'b1}}, {USE_SHIFT{1'b0}}};

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
        (USE_DATA_BYTE % MEM_DATA_BYTE) != 0 ||
        READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_params
        $fatal(1, "byte_serializer: illegal parameter set");
    end

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   is_write_q;
    logic [USE_DATA_BYTE-1:0] mask_q;
    logic [USE_BITS-1:0]    wdata_q;
    logic [ADDR_SIZE-1:0]   base_q;
    logic [USE_BITS-1:0]    rbuf_q;
    logic [USE_BITS-1:0]    rbuf_next;
    logic [USE_BITS-1:0]    rdata_q;

    logic                   first_found;
    logic [IDX_W-1:0]       first_idx;
    logic                   next_found;
    logic [IDX_W-1:0]       next_idx;
    logic                   read_accept;
    logic                   ret_valid;
    logic [IDX_W-1:0]       ret_idx;
    logic                   pending;

    // A beat is skipped only for writes whose mask slice is entirely off.
    function automatic logic beat_live(input logic [USE_DATA_BYTE-1:0] m,
                                       input logic wr, input int i);
        return !(wr && (SKIP_EMPTY != 0) &&
                 (m[i*MEM_DATA_BYTE +: MEM_DATA_BYTE] == '0));
    endfunction

    // Descending scans leave the lowest qualifying index in the result.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (beat_live(useWriteMask_i, useIsWrite_i, i)) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (i > int'(idx_q) && beat_live(mask_q, is_write_q, i)) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end
    end

    assign read_accept = (state_q == ST_ISSUE) && !memHold_i && !is_write_q;

    read_return_pipe #(
        .LATENCY (READ_LATENCY),
        .IDX_W   (IDX_W)
    ) u_pipe (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (read_accept),
        .push_idx  (idx_q),
        .ret_valid (ret_valid),
        .ret_idx   (ret_idx),
        .pending   (pending)
    );

    always_comb begin
        rbuf_next = rbuf_q;
        if (ret_valid) begin
            rbuf_next[int'(ret_idx)*MEM_BITS +: MEM_BITS] = memReadData_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            is_write_q <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
            base_q     <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
        end else begin
            rbuf_q <= rbuf_next;
            case (state_q)
                ST_IDLE: begin
                    if (useEnable_i) begin
                        is_write_q <= useIsWrite_i;
                        mask_q     <= useWriteMask_i;
                        wdata_q    <= useWriteData_i;
                        base_q     <= useAddr_i & BASE_MASK;
                        idx_q      <= first_idx;
                        state_q    <= first_found ? ST_ISSUE : ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    if (!memHold_i) begin
                        if (next_found) begin
                            idx_q <= next_idx;
                        end else begin
                            state_q <= is_write_q ? ST_DONE : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Publish the word together with its final returning slice.
                    if (!pending) begin
                        rdata_q <= rbuf_next;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory-side outputs decode straight from registered state, so they
    // cannot move while a beat is held.
    always_comb begin
        memEnable_o    = 1'b0;
        memIsWrite_o   = 1'b0;
        memWriteMask_o = '0;
        memAddr_o      = '0;
        memWriteData_o = '0;
        if (state_q == ST_ISSUE) begin
            memEnable_o  = 1'b1;
            memIsWrite_o = is_write_q;
            memAddr_o    = base_q + ADDR_SIZE'(int'(idx_q) * MEM_DATA_BYTE);
            if (is_write_q) begin
                memWriteMask_o = mask_q[int'(idx_q)*MEM_DATA_BYTE +: MEM_DATA_BYTE];
                memWriteData_o = wdata_q[int'(idx_q)*MEM_BITS +: MEM_BITS];
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_IDLE: useHold_o = useEnable_i;
            ST_DONE: useHold_o = 1'b0;
            default: useHold_o = 1'b1;
        endcase
    end

    assign useReadData_o = rdata_q;

endmodule
